// File: rtl/sd_bitstream_decimator.sv
// sd_bitstream_decimator
//   Counts ones in the comparator bitstream over back-to-back windows of
//   2^OSR_LOG2 clocks and hands each count to a 2-entry valid/ready buffer.
//
// Ports
//   clk       : clock, all state on rising edge
//   rst_n     : async active-low reset
//   en        : level enable, accumulate while high
//   clear     : synchronous flush (everything except rst_n yields to it)
//   bit_in    : comparator bit, one per clock
//   out_data  : head-of-buffer sample (ones count, 0..W)
//   out_valid : buffer non-empty
//   out_ready : consumer handshake
//   overrun   : sticky, a finished window was dropped on a full buffer
//   busy      : state == ACCUM
module sd_bitstream_decimator #(
  parameter  int OSR_LOG2 = 6,
  localparam int OUT_W    = OSR_LOG2 + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clear,
  input  logic             bit_in,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             busy
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t              state;
  logic [OSR_LOG2-1:0] cnt;
  logic [OUT_W-1:0]    acc;
  logic [OUT_W-1:0]    sum;
  logic                win_end;

  // Window result staging: decouples the buffer from bit_in so out_data
  // never sees a combinational path from the bitstream.
  logic                push_q;
  logic [OUT_W-1:0]    result_q;

  // 2-entry buffer: head drives out_data directly.
  logic [OUT_W-1:0]    head, tail;
  logic [1:0]          occ;
  logic                pop;

  assign sum     = acc + OUT_W'(bit_in);
  assign win_end = (state == ACCUM) && en && (&cnt);
  assign pop     = out_valid && out_ready;

  assign out_data  = head;
  assign out_valid = (occ != 2'd0);
  assign busy      = (state == ACCUM);

  // Window accumulator FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      push_q   <= 1'b0;
      result_q <= '0;
    end else if (clear) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      push_q   <= 1'b0;
    end else begin
      push_q <= win_end;
      if (win_end) result_q <= sum;
      case (state)
        IDLE: begin
          // bit_in on the cycle en is first seen is not counted
          if (en) state <= ACCUM;
        end
        ACCUM: begin
          if (!en) begin
            // partial window is abandoned, nothing pushed
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
          end else if (&cnt) begin
            acc <= '0;
            cnt <= '0;
          end else begin
            acc <= sum;
            cnt <= cnt + OSR_LOG2'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      occ     <= 2'd0;
      overrun <= 1'b0;
    end else if (clear) begin
      // head keeps its value; only occupancy matters once empty
      occ     <= 2'd0;
      overrun <= 1'b0;
    end else begin
      case (occ)
        2'd0: begin
          if (push_q) begin
            head <= result_q;
            occ  <= 2'd1;
          end
        end
        2'd1: begin
          if (push_q && pop) begin
            head <= result_q;
          end else if (push_q) begin
            tail <= result_q;
            occ  <= 2'd2;
          end else if (pop) begin
            occ <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head <= tail;
            if (push_q) tail <= result_q;
            else        occ  <= 2'd1;
          end else if (push_q) begin
            // full and not draining: drop the new sample
            overrun <= 1'b1;
          end
        end
        default: occ <= 2'd0;
      endcase
    end
  end

endmodule
